// File: rtl/id_alloc.sv
// id_alloc: lowest-first ID allocator with a registered valid/ready offer slot and a single-cycle release port
module id_alloc #(
  parameter int NUM_IDS   = 8,
  parameter int ID_WIDTH  = $clog2(NUM_IDS) + (NUM_IDS == 1),
  parameter int CNT_WIDTH = $clog2(NUM_IDS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  output logic                 alloc_valid_o,
  input  logic                 alloc_ready_i,
  output logic [ID_WIDTH-1:0]  alloc_id_o,
  input  logic                 free_valid_i,
  input  logic [ID_WIDTH-1:0]  free_id_i,
  output logic [CNT_WIDTH-1:0] in_use_o,
  output logic                 full_o,
  output logic                 err_o
);
  logic [NUM_IDS-1:0]   free_q, pick_oh, rel_oh;
  logic [ID_WIDTH-1:0]  offer_id_q, pick_id;
  logic [CNT_WIDTH-1:0] in_use_q;
  logic                 offer_valid_q, err_q, empty, load, accept, rel_ok;

  assign empty   = ~|free_q;
  assign load    = !offer_valid_q || alloc_ready_i;
  assign accept  = offer_valid_q && alloc_ready_i;
  assign pick_oh = load ? (free_q & (~free_q + 1'b1)) : '0;
  assign rel_ok  = |rel_oh;

  // trailing-zero count of the free bitmap: lowest free index wins
  always_comb begin
    pick_id = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) if (free_q[i]) pick_id = ID_WIDTH'(i);
  end

  // one-hot of a legal release; out-of-range IDs never match any bit so they fall out as illegal
  always_comb begin
    rel_oh = '0;
    for (int i = 0; i < NUM_IDS; i++)
      rel_oh[i] = free_valid_i && free_id_i == ID_WIDTH'(i) && !free_q[i] &&
                  !(offer_valid_q && offer_id_q == free_id_i);
  end

  // bitmap, offer slot, in-use count and error flag; flush shares the reset path
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      free_q        <= '1;
      offer_valid_q <= 1'b0;
      offer_id_q    <= '0;
      in_use_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      free_q   <= (free_q & ~pick_oh) | rel_oh;
      in_use_q <= in_use_q + CNT_WIDTH'(accept) - CNT_WIDTH'(rel_ok);
      err_q    <= free_valid_i && !rel_ok;
      if (load) offer_valid_q <= !empty;
      if (load && !empty) offer_id_q <= pick_id;
    end
  end

  assign alloc_valid_o = offer_valid_q;
  assign alloc_id_o    = offer_id_q;
  assign in_use_o      = in_use_q;
  assign full_o        = in_use_q == CNT_WIDTH'(NUM_IDS);
  assign err_o         = err_q;
endmodule

// File: tb/tb_id_alloc.sv
// tb_id_alloc: directed plus randomized check of id_alloc against an ownership-set reference model
module tb_id_alloc;
  localparam int N = 8;
  logic       clk = 0, rst_n = 0, flush = 0, ready = 0, fv = 0;
  logic [2:0] fid = '0;
  logic       alloc_valid, full, err;
  logic [2:0] alloc_id;
  logic [3:0] in_use;
  logic       rst10_n = 0, fv10 = 0, a10_valid, a10_full, a10_err;
  logic [3:0] fid10 = '0, a10_id, a10_in_use;
  int n_cmp = 0, n_err = 0;
  bit owned[N];
  bit m_v, m_err;
  int m_id;

  always #5 clk = ~clk;

  id_alloc #(.NUM_IDS(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .alloc_valid_o(alloc_valid), .alloc_ready_i(ready), .alloc_id_o(alloc_id),
    .free_valid_i(fv), .free_id_i(fid),
    .in_use_o(in_use), .full_o(full), .err_o(err)
  );

  id_alloc #(.NUM_IDS(10)) dut10 (
    .clk_i(clk), .rst_ni(rst10_n), .flush_i(1'b0),
    .alloc_valid_o(a10_valid), .alloc_ready_i(1'b0), .alloc_id_o(a10_id),
    .free_valid_i(fv10), .free_id_i(fid10),
    .in_use_o(a10_in_use), .full_o(a10_full), .err_o(a10_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int owned_cnt();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(owned[i]);
    return c;
  endfunction

  // reference: a released ID must be owned (accepted, not offered); pick is lowest ID neither owned nor on offer
  task automatic model_step();
    bit legal, acc, ld, found;
    int pick;
    if (!rst_n || flush) begin
      owned = '{default: 0};
      m_v = 0; m_id = 0; m_err = 0;
      return;
    end
    legal = fv && int'(fid) < N && owned[fid];
    acc   = m_v && ready;
    ld    = !m_v || ready;
    found = 0; pick = 0;
    for (int i = N - 1; i >= 0; i--)
      if (!owned[i] && !(m_v && m_id == i)) begin found = 1; pick = i; end
    m_err = fv && !legal;
    if (acc) owned[m_id] = 1;
    if (legal) owned[fid] = 0;
    if (ld) begin
      m_v = found;
      if (found) m_id = pick;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("valid", alloc_valid, m_v);
    chk("id", alloc_id, m_id);
    chk("in_use", in_use, owned_cnt());
    chk("full", full, owned_cnt() == N);
    chk("err", err, m_err);
  endtask

  task automatic fill(input int n);
    ready = 1;
    repeat (n) tick();
    ready = 0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_valid", alloc_valid, 0);
    chk("rst_id", alloc_id, 0);
    chk("rst_in_use", in_use, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    rst_n = 1;
    tick();
    chk("first_offer_valid", alloc_valid, 1);
    chk("first_offer_id", alloc_id, 0);
    repeat (5) begin
      tick();
      chk("bp_valid", alloc_valid, 1);
      chk("bp_id", alloc_id, 0);
    end
    ready = 1;
    tick();
    chk("bp_next_id", alloc_id, 1);
    chk("bp_in_use", in_use, 1);
    rst_n = 0; ready = 0;
    tick();
    rst_n = 1; ready = 1;
    tick();
    for (int k = 0; k < N; k++) begin
      chk("stream_valid", alloc_valid, 1);
      chk("stream_id", alloc_id, k);
      tick();
    end
    ready = 0;
    chk("stream_end_valid", alloc_valid, 0);
    chk("stream_in_use", in_use, 8);
    chk("stream_full", full, 1);
    fv = 1; fid = 5;
    tick();
    chk("ooo_in_use_7", in_use, 7);
    chk("ooo_full", full, 0);
    fid = 2;
    tick();
    chk("ooo_in_use_6", in_use, 6);
    chk("ooo_offer_5", alloc_id, 5);
    fv = 0; ready = 1;
    tick();
    chk("ooo_offer_2", alloc_id, 2);
    chk("ooo_in_use_up", in_use, 7);
    tick();
    chk("ooo_refull", in_use, 8);
    ready = 0; fv = 1; fid = 3;
    tick();
    chk("rel3_err", err, 0);
    tick();
    chk("dbl_err", err, 1);
    chk("dbl_in_use", in_use, 7);
    chk("dbl_offer_3", alloc_id, 3);
    tick();
    chk("offered_err", err, 1);
    chk("offered_in_use", in_use, 7);
    chk("offered_valid", alloc_valid, 1);
    fv = 0;
    tick();
    chk("err_pulse_end", err, 0);
    ready = 1; fv = 1; fid = 3;
    tick();
    chk("acc_offered_err", err, 1);
    chk("acc_offered_in_use", in_use, 8);
    ready = 0; fid = 4;
    tick();
    fv = 0;
    tick();
    chk("sim_offer_4", alloc_id, 4);
    ready = 1; fv = 1; fid = 1;
    tick();
    chk("sim_in_use", in_use, 7);
    chk("sim_no_early_1", alloc_valid, 0);
    fv = 0;
    tick();
    chk("sim_offer_1", alloc_id, 1);
    chk("sim_offer_1_valid", alloc_valid, 1);
    ready = 0; flush = 1;
    tick();
    flush = 0;
    tick();
    fill(6);
    chk("pre_flush_in_use", in_use, 6);
    flush = 1; ready = 1; fv = 1; fid = 2;
    tick();
    flush = 0; ready = 0; fv = 0;
    chk("flush_in_use", in_use, 0);
    chk("flush_valid", alloc_valid, 0);
    chk("flush_err", err, 0);
    tick();
    chk("flush_reoffer", alloc_id, 0);
    chk("flush_reoffer_valid", alloc_valid, 1);
    fill(6);
    rst_n = 0;
    tick();
    chk("midrst_in_use", in_use, 0);
    chk("midrst_valid", alloc_valid, 0);
    rst_n = 1;
    tick();
    chk("midrst_reoffer", alloc_id, 0);
    chk("midrst_reoffer_valid", alloc_valid, 1);
    for (int c = 0; c < 3000; c++) begin
      rst_n = $urandom_range(199) != 0;
      flush = $urandom_range(79) == 0;
      ready = $urandom_range(2) != 0;
      fv    = $urandom_range(1) == 1;
      fid   = 3'($urandom_range(N - 1));
      tick();
    end
    rst_n = 1; flush = 0; ready = 0; fv = 0;
    rst10_n = 1;
    tick();
    chk("n10_offer_valid", a10_valid, 1);
    chk("n10_offer_id", a10_id, 0);
    fv10 = 1; fid10 = 9;
    tick();
    chk("n10_free9_err", a10_err, 1);
    chk("n10_free9_in_use", a10_in_use, 0);
    fid10 = 12;
    tick();
    chk("n10_oor_err", a10_err, 1);
    chk("n10_oor_in_use", a10_in_use, 0);
    fv10 = 0;
    tick();
    chk("n10_err_end", a10_err, 0);
    chk("n10_offer_kept", a10_id, 0);
    chk("n10_full", a10_full, 0);
    fid10 = 0; fv10 = 1;
    tick();
    chk("n10_offered_err", a10_err, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
